// File: rtl/fetcher.sv
// fetcher: instruction fetch responder with a direct-mapped instruction cache
// in front of a valid/ready program-memory read channel.
module fetcher #(
   parameter int PROGRAM_MEM_ADDR_BITS = 8,
   parameter int PROGRAM_MEM_DATA_BITS = 16,
   parameter int CACHE_LINES = 8,
   parameter int CACHE_EN = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic [2:0] core_state,
   input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
   output logic mem_read_valid,
   output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
   input  logic mem_read_ready,
   input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
   output logic [2:0] fetcher_state,
   output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
   output logic [15:0] hit_count,
   output logic [15:0] miss_count
);
   localparam int IB = $clog2(CACHE_LINES);
   localparam int TB = PROGRAM_MEM_ADDR_BITS - IB;
   localparam logic [2:0] CORE_FETCH = 3'b001;
   localparam logic [2:0] CORE_DECODE = 3'b010;
   typedef enum logic [2:0] {IDLE = 3'b000, FETCHING = 3'b001, FETCHED = 3'b010} state_t;
   state_t state, state_n;
   logic [PROGRAM_MEM_DATA_BITS-1:0] line_data [CACHE_LINES];
   logic [TB-1:0] line_tag [CACHE_LINES];
   logic [CACHE_LINES-1:0] line_valid;
   logic [IB-1:0] pc_idx, req_idx;
   logic [TB-1:0] pc_tag, req_tag;
   logic hit, start, done, fill;
   assign pc_idx = current_pc[IB-1:0];
   assign pc_tag = current_pc[PROGRAM_MEM_ADDR_BITS-1:IB];
   assign req_idx = mem_read_address[IB-1:0];
   assign req_tag = mem_read_address[PROGRAM_MEM_ADDR_BITS-1:IB];
   assign hit = (CACHE_EN != 0) && line_valid[pc_idx] && line_tag[pc_idx] == pc_tag;
   assign start = state == IDLE && core_state == CORE_FETCH;
   assign done = state == FETCHING && mem_read_valid && mem_read_ready;
   assign fill = done && (CACHE_EN != 0);
   assign fetcher_state = state;
   always_comb begin
      state_n = state;
      state_n = start ? (hit ? FETCHED : FETCHING)
              : done ? FETCHED
              : (state == FETCHED && core_state == CORE_DECODE) ? IDLE
              : state;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         mem_read_valid <= 1'b0;
         mem_read_address <= '0;
         instruction <= '0;
         hit_count <= '0;
         miss_count <= '0;
      end else begin
         state <= state_n;
         if (start && hit) begin
            instruction <= line_data[pc_idx];
            hit_count <= hit_count + {15'b0, ~&hit_count};
         end
         if (start && !hit) begin
            mem_read_valid <= 1'b1;
            mem_read_address <= current_pc;
            miss_count <= miss_count + {15'b0, ~&miss_count};
         end
         if (done) begin
            instruction <= mem_read_data;
            mem_read_valid <= 1'b0;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (reset) line_valid <= '0;
      else if (fill) line_valid[req_idx] <= 1'b1;
   end
   // Payload arrays need no reset; the valid bits gate every use.
   always_ff @(posedge clk) begin
      if (fill) begin
         line_data[req_idx] <= mem_read_data;
         line_tag[req_idx] <= req_tag;
      end
   end
endmodule

// File: tb/tb_fetcher.sv
// tb_fetcher: directed fetch sequences on a cached and an uncached fetcher,
// checked every cycle against a transaction-level model plus literal pins.
module tb_fetcher;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;
   logic [2:0] cs [2];
   logic [7:0] pc [2];
   logic rdy [2];
   logic [15:0] rdat [2];
   logic mv [2];
   logic [7:0] ma [2];
   logic [2:0] fs [2];
   logic [15:0] ins [2], hc [2], mc [2];
   int total = 0;
   int bad = 0;
   fetcher #(.CACHE_EN(1)) dut (
      .clk(clk), .reset(reset), .core_state(cs[0]), .current_pc(pc[0]),
      .mem_read_valid(mv[0]), .mem_read_address(ma[0]), .mem_read_ready(rdy[0]),
      .mem_read_data(rdat[0]), .fetcher_state(fs[0]), .instruction(ins[0]),
      .hit_count(hc[0]), .miss_count(mc[0]));
   fetcher #(.CACHE_EN(0)) dut_nc (
      .clk(clk), .reset(reset), .core_state(cs[1]), .current_pc(pc[1]),
      .mem_read_valid(mv[1]), .mem_read_address(ma[1]), .mem_read_ready(rdy[1]),
      .mem_read_data(rdat[1]), .fetcher_state(fs[1]), .instruction(ins[1]),
      .hit_count(hc[1]), .miss_count(mc[1]));
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s got=%h want=%h", n, a, e);
      end
   endtask
   // Model: per instance, outputs as plain integers; cache as line -> cached pc (-1 empty).
   int m_st [2], m_v [2], m_a [2], m_i [2], m_h [2], m_m [2];
   int lpc [2][8];
   int ldat [2][8];
   bit started = 0;
   always @(posedge clk) begin
      started = 1;
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            m_st[i] = 0; m_v[i] = 0; m_a[i] = 0; m_i[i] = 0; m_h[i] = 0; m_m[i] = 0;
            for (int k = 0; k < 8; k++) lpc[i][k] = -1;
         end else if (m_st[i] == 0) begin
            if (cs[i] == 3'd1) begin
               if (i == 0 && lpc[i][int'(pc[i]) % 8] == int'(pc[i])) begin
                  m_i[i] = ldat[i][int'(pc[i]) % 8];
                  m_st[i] = 2;
                  m_h[i] = m_h[i] < 65535 ? m_h[i] + 1 : m_h[i];
               end else begin
                  m_v[i] = 1;
                  m_a[i] = int'(pc[i]);
                  m_st[i] = 1;
                  m_m[i] = m_m[i] < 65535 ? m_m[i] + 1 : m_m[i];
               end
            end
         end else if (m_st[i] == 1) begin
            if (rdy[i]) begin
               m_i[i] = int'(rdat[i]);
               m_v[i] = 0;
               m_st[i] = 2;
               if (i == 0) begin
                  lpc[i][m_a[i] % 8] = m_a[i];
                  ldat[i][m_a[i] % 8] = int'(rdat[i]);
               end
            end
         end else if (cs[i] == 3'd2) m_st[i] = 0;
      end
   end
   always @(negedge clk) begin
      if (started) begin
         for (int i = 0; i < 2; i++) begin
            chk($sformatf("state%0d", i), 32'(fs[i]), m_st[i]);
            chk($sformatf("valid%0d", i), 32'(mv[i]), m_v[i]);
            chk($sformatf("addr%0d", i), 32'(ma[i]), m_a[i]);
            chk($sformatf("instr%0d", i), 32'(ins[i]), m_i[i]);
            chk($sformatf("hits%0d", i), 32'(hc[i]), m_h[i]);
            chk($sformatf("misses%0d", i), 32'(mc[i]), m_m[i]);
         end
      end
   end
   task automatic tick();
      @(posedge clk);
      #2;
   endtask
   // Requests pc p; memory answers lat cycles after valid is first seen.
   task automatic fetch(input int i, input logic [7:0] p, input int lat, input logic [15:0] d,
                        output int vcyc, output int fcyc);
      cs[i] = 3'd1;
      pc[i] = p;
      vcyc = 0;
      fcyc = 0;
      for (int n = 0; n < 100; n++) begin
         tick();
         fcyc++;
         if (fs[i] == 3'd2) break;
         if (mv[i]) vcyc++;
         rdy[i] = mv[i] && vcyc == lat + 1;
         rdat[i] = d;
      end
      rdy[i] = 1'b0;
      chk("fetch_done", 32'(fs[i]), 2);
      cs[i] = 3'd2;
      tick();
      cs[i] = 3'd0;
      tick();
   endtask
   initial begin
      int v, f;
      for (int i = 0; i < 2; i++) begin
         cs[i] = 3'd0; pc[i] = 8'h00; rdy[i] = 1'b0; rdat[i] = 16'h0000;
      end
      tick();
      tick();
      chk("reset_state", 32'(fs[0]), 0);
      chk("reset_valid", 32'(mv[0]), 0);
      chk("reset_instr", 32'(ins[0]), 0);
      reset = 1'b0;
      fetch(0, 8'h00, 2, 16'h5123, v, f);
      chk("miss_valid_cycles", v, 3);
      chk("miss_instr", 32'(ins[0]), 32'h5123);
      chk("miss_count1", 32'(mc[0]), 1);
      fetch(0, 8'h00, 2, 16'hFFFF, v, f);
      chk("hit_no_valid", v, 0);
      chk("hit_latency", f, 1);
      chk("hit_count1", 32'(hc[0]), 1);
      chk("hit_instr", 32'(ins[0]), 32'h5123);
      fetch(0, 8'h08, 1, 16'hA808, v, f);
      chk("alias_miss", 32'(mc[0]), 2);
      chk("alias_instr", 32'(ins[0]), 32'hA808);
      fetch(0, 8'h00, 0, 16'h5123, v, f);
      chk("evicted_miss", 32'(mc[0]), 3);
      fetch(0, 8'h00, 0, 16'h0BAD, v, f);
      chk("refill_hit", 32'(hc[0]), 2);
      chk("refill_instr", 32'(ins[0]), 32'h5123);
      cs[0] = 3'd1;
      pc[0] = 8'h21;
      tick();
      for (int n = 0; n < 20; n++) begin
         chk("stall_valid", 32'(mv[0]), 1);
         chk("stall_addr", 32'(ma[0]), 32'h21);
         chk("stall_state", 32'(fs[0]), 1);
         tick();
      end
      rdy[0] = 1'b1;
      rdat[0] = 16'h2121;
      tick();
      rdy[0] = 1'b0;
      chk("stall_done", 32'(fs[0]), 2);
      chk("stall_instr", 32'(ins[0]), 32'h2121);
      cs[0] = 3'd2;
      tick();
      cs[0] = 3'd0;
      tick();
      pc[0] = 8'h30;
      cs[0] = 3'd1;
      tick();
      tick();
      reset = 1'b1;
      cs[0] = 3'd0;
      tick();
      reset = 1'b0;
      rdy[0] = 1'b1;
      rdat[0] = 16'hDEAD;
      tick();
      tick();
      chk("rst_state", 32'(fs[0]), 0);
      chk("rst_valid", 32'(mv[0]), 0);
      chk("rst_addr", 32'(ma[0]), 0);
      chk("rst_instr", 32'(ins[0]), 0);
      chk("rst_hits", 32'(hc[0]), 0);
      chk("rst_misses", 32'(mc[0]), 0);
      rdy[0] = 1'b0;
      fetch(0, 8'h00, 0, 16'h7000, v, f);
      chk("post_rst_miss", v, 1);
      chk("post_rst_count", 32'(mc[0]), 1);
      fetch(1, 8'h03, 1, 16'hC003, v, f);
      chk("nc_first", v, 2);
      fetch(1, 8'h03, 1, 16'hC003, v, f);
      chk("nc_second", v, 2);
      chk("nc_hits", 32'(hc[1]), 0);
      chk("nc_misses", 32'(mc[1]), 2);
      chk("nc_instr", 32'(ins[1]), 32'hC003);
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
